// File: rtl/assertion_violation_reporter.sv
// assertion_violation_reporter
// Receives the assertion fabric's per-assertion violation levels and finds rising edges.
// It keeps a sticky pending mask and an irq for software.
// Each new violation is queued as one {id, timestamp} event in a small show-ahead FIFO,
// which a downstream consumer drains with a valid/ready handshake.
module assertion_violation_reporter #(
  parameter int NUM_ASSERTS = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TS_WIDTH    = 16,
  localparam int ID_W  = $clog2(NUM_ASSERTS),
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   assertionViolated,
  input  logic [NUM_ASSERTS-1:0] assertionsViolated,
  input  logic                   clearStrobe,
  input  logic [NUM_ASSERTS-1:0] clearMask,
  output logic                   evtValid,
  input  logic                   evtReady,
  output logic [ID_W-1:0]        evtId,
  output logic [TS_WIDTH-1:0]    evtTime,
  output logic [NUM_ASSERTS-1:0] pending,
  output logic                   irq,
  output logic [7:0]             dropCount
);

  logic [NUM_ASSERTS-1:0] prev_q, prev_d;
  logic [NUM_ASSERTS-1:0] pending_q, pending_d;
  logic [NUM_ASSERTS-1:0] to_send_q, to_send_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [7:0]             drop_q, drop_d;
  logic                   irq_q, irq_d;
  logic [ID_W-1:0]        mem_id_q [FIFO_DEPTH];
  logic [ID_W-1:0]        mem_id_d [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]    mem_ts_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]    mem_ts_d [FIFO_DEPTH];

  logic [NUM_ASSERTS-1:0] rise_s;
  logic [NUM_ASSERTS-1:0] clr_s;
  logic [NUM_ASSERTS-1:0] grant_s;
  logic [ID_W-1:0]        grant_idx_s;
  logic                   full_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   merged_s;

  // Edge detection and lowest-index grant of pending-to-enqueue violations
  always_comb begin
    rise_s      = '0;
    clr_s       = '0;
    grant_s     = '0;
    grant_idx_s = '0;
    full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    if (enable && assertionViolated) begin
      rise_s = assertionsViolated & ~prev_q;
    end else begin
      rise_s = '0;
    end
    if (clearStrobe) begin
      clr_s = clearMask;
    end else begin
      clr_s = '0;
    end
    // Full is judged on the registered count, so a same-cycle pop never opens a slot
    if ((to_send_q != '0) && !full_s) begin
      // Descending scan leaves the lowest set index in grant_idx_s
      for (int i = NUM_ASSERTS - 1; i >= 0; i--) begin
        grant_idx_s = to_send_q[i] ? ID_W'(i) : grant_idx_s;
      end
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s     = '0;
      grant_idx_s = '0;
    end
    push_s   = |grant_s;
    pop_s    = (count_q != '0) && evtReady;
    // A rise on a bit still waiting to be enqueued folds into the waiting event
    merged_s = |(rise_s & to_send_q & ~grant_s);
  end

  // Next-state computation for masks, timestamp, FIFO bookkeeping and counters
  always_comb begin
    prev_d    = assertionsViolated;
    pending_d = (pending_q & ~clr_s) | rise_s;
    to_send_d = (to_send_q & ~grant_s) | rise_s;
    irq_d     = |pending_q;
    mem_id_d  = mem_id_q;
    mem_ts_d  = mem_ts_q;
    if (enable) begin
      ts_d = ts_q + TS_WIDTH'(1);
    end else begin
      ts_d = ts_q;
    end
    if (merged_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
    if (push_s) begin
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      mem_id_d[wr_ptr_q] = grant_idx_s;
      mem_ts_d[wr_ptr_q] = ts_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      to_send_q <= '0;
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= 8'd0;
      irq_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_id_q[i] <= '0;
        mem_ts_q[i] <= '0;
      end
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      to_send_q <= to_send_d;
      ts_q      <= ts_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      irq_q     <= irq_d;
      mem_id_q  <= mem_id_d;
      mem_ts_q  <= mem_ts_d;
    end
  end

  // Show-ahead head; id/time read as zero whenever the FIFO is empty
  always_comb begin
    evtValid = (count_q != '0);
    if (evtValid) begin
      evtId   = mem_id_q[rd_ptr_q];
      evtTime = mem_ts_q[rd_ptr_q];
    end else begin
      evtId   = '0;
      evtTime = '0;
    end
    pending   = pending_q;
    irq       = irq_q;
    dropCount = drop_q;
  end

endmodule

// File: doc/assertion_violation_reporter.md
# assertion_violation_reporter

Consumer-side endpoint of the assertion fabric's violation interface. It watches the fabric's per-assertion violation vector and detects rising edges. It keeps a sticky pending mask for software and queues one timestamped event per new violation into a small FIFO, which a downstream trap/CPU unit drains over a valid/ready handshake. It sits directly after the assertion fabric; its inputs are the fabric's `assertionViolated` / `assertionsViolated` outputs.

## Interface
- `NUM_ASSERTS`, 32: width of violation vector; event id width is clog2(NUM_ASSERTS) = 5.
- `FIFO_DEPTH`, 4: event FIFO entries, power of two.
- `TS_WIDTH`, 16: timestamp counter width.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `enable`  in  1  capture enable; also gates the timestamp counter.
- `assertionViolated`  in  1  fabric summary OR; a rise is captured only when this is 1 in the same cycle.
- `assertionsViolated`  in  NUM_ASSERTS  per-assertion violation levels from fabric.
- `clearStrobe`  in  1  one-cycle request to clear pending bits.
- `clearMask`  in  NUM_ASSERTS  bits to clear when `clearStrobe`=1.
- `evtValid`  out  1  FIFO head valid.
- `evtReady`  in  1  consumer accepts head.
- `evtId`  out  5  assertion index of head event.
- `evtTime`  out  TS_WIDTH  timestamp of head event.
- `pending`  out  NUM_ASSERTS  sticky violation mask.
- `irq`  out  1  registered, = |pending.
- `dropCount`  out  8  saturating count of lost events.

## Operation
- `prev`: register of `assertionsViolated`, updated every cycle regardless of `enable`.
  - A level already high when `enable` rises is never reported.
- `rise = assertionsViolated & ~prev`, masked to 0 unless `enable`=1 and `assertionViolated`=1.
- `pending` update: `pending <= (pending & ~(clearStrobe ? clearMask : 0)) | rise`.
  - Set wins over clear on the same bit in the same cycle.
- `toSend` register holds violations detected but not yet enqueued.
  - `toSend <= (toSend & ~grant) | rise`.
- Enqueue:
  - Each cycle, if `toSend`≠0 and the FIFO count < FIFO_DEPTH (registered count, before any same-cycle pop), select the lowest set index of `toSend` (`grant`, one-hot).
  - Push {index, `ts`} and clear that bit.
  - At most one push per cycle.
  - If the FIFO is full, `toSend` holds; nothing is lost.
- Drop: if a `rise` bit is already set in `toSend` and not granted this cycle, the new event merges into the existing one.
  - `dropCount` increments by 1 per such cycle, saturating at 255. Multiple merged bits in one cycle still count as one increment.
- Timestamp `ts`: TS_WIDTH counter, increments each cycle while `enable`=1, holds otherwise, wraps 0xFFFF→0.
- FIFO: show-ahead. `evtValid` = count≠0; `evtId`/`evtTime` = head entry.
  - Pop when `evtValid & evtReady`.
  - Push and pop in the same cycle are allowed when count was < FIFO_DEPTH; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO drains while `enable`=0.
- Reset (`rst`=0, asynchronous): `prev`, `pending`, `toSend`, `ts`, FIFO pointers and count, `dropCount`, `irq` all → 0; `evtValid`=0, `evtId`=0, `evtTime`=0.
  - Reset mid-operation discards queued events.

## Timing
- Violation level first high at edge E0 (with `enable`=1): `pending`, `toSend` set at E0.
  - Pushed at E1 if FIFO not full; `evtValid`=1 after E1; `evtTime` = `ts` value sampled at E1.
  - `irq`=1 after E1.
- N simultaneous rises at E0: pushed at E1..EN in ascending index order.
- Pop at edge P: next head is visible after P; `evtValid` falls after P if the FIFO is empty.
- `evtId`/`evtTime` stay stable while `evtValid`=1 and `evtReady`=0.
- Clear at edge C: `pending` bit low after C; `irq` follows one cycle later (registered from `pending`).

## Test plan
- Reset with all inputs 0 → all outputs 0. Release `rst`, `enable`=1, raise bit 7 (with `assertionViolated`=1) at cycle 10 → `pending`=0x80, `evtValid`=1 with `evtId`=7, `evtTime`=`ts` at enqueue; `evtReady`=1 → `evtValid`=0 next cycle.
- Raise bits 3, 1, 30 together with `evtReady`=0 → events enqueued 1, 3, 30 on consecutive cycles; FIFO count 3; `pending`=0x4000000A.
- Hold `evtReady`=0 and produce 6 distinct rises → 4 queued, 2 held in `toSend`, `dropCount`=0. Drain → all 6 ids delivered in order.
- With bit 5 held in `toSend` (FIFO full), pulse bit 5 low then high → `dropCount`=1. Repeat 300 times → `dropCount`=255.
- `clearStrobe` with `clearMask`=0x80 in the same cycle bit 7 rises → bit 7 stays set; next `clearStrobe` clears it, `irq` falls one cycle later.
- Bit 2 high before `enable` rises → no event. Assert `rst`=0 with 3 queued events → `evtValid`=0 immediately (async); after release, no stale events.
